// File: rtl/dpu_arb_pkg.sv
// Shared types and constants for the DPU memory-port arbiter.
package dpu_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Ceiling log2, usable in parameter defaults.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/dpu_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Optional macro DPU_ARB_PRIO0_EN: requester 0 wins whenever it requests.
module dpu_rr_pick
  import dpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned ID_WIDTH = clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> ptr;

  // Scan the rotated vector so offset 0 corresponds to the pointer position.
  always_comb begin
    int unsigned sum;
    winner = '0;
    valid  = 1'b0;
    sum    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!valid && req_rot[k]) begin
        valid = 1'b1;
        sum   = 32'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        winner = sum[ID_WIDTH-1:0];
      end
    end
`ifdef DPU_ARB_PRIO0_EN
    if (req[0]) begin
      valid  = 1'b1;
      winner = '0;
    end
`endif
  end

endmodule

// File: rtl/dpu_mem_arbiter.sv
// Transaction-level round-robin arbiter for the shared DPU memory port.
// Holds a grant for a whole burst, counting beats until the last one.
// Optional macro DPU_ARB_PRIO0_EN: requester 0 (MOVER) has arbitration priority.
module dpu_mem_arbiter
  import dpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int unsigned ID_WIDTH  = clog2(DEF_NUM_REQ)
) (
  input  logic                         SYS_CLK,
  input  logic                         SYS_RST,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] REQ_LEN,
  input  logic                         BEAT_VALID,
  input  logic                         BEAT_READY,
  output logic [NUM_REQ-1:0]           GNT,
  output logic [ID_WIDTH-1:0]          GNT_ID,
  output logic                         BUSY,
  output logic                         DONE
);

  arb_state_t            state, state_n;
  logic [ID_WIDTH-1:0]   ptr, ptr_n, ptr_adv;
  logic [ID_WIDTH-1:0]   win;
  logic                  win_valid;
  logic [LEN_WIDTH-1:0]  cnt, cnt_n, win_len;
  logic [NUM_REQ-1:0]    gnt_n;
  logic [ID_WIDTH-1:0]   gnt_id_n;
  logic                  busy_n, done_n;
  logic                  beat;

  assign beat = BEAT_VALID & BEAT_READY;

  dpu_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req    (REQ),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  // Burst length of the current winner and the pointer position after it.
  always_comb begin
    int unsigned nxt;
    win_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == ID_WIDTH'(i)) win_len = REQ_LEN[i*LEN_WIDTH +: LEN_WIDTH];
    end
    nxt = 32'(win) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    ptr_adv = nxt[ID_WIDTH-1:0];
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n  = state;
    gnt_n    = GNT;
    gnt_id_n = GNT_ID;
    busy_n   = BUSY;
    done_n   = 1'b0;
    cnt_n    = cnt;
    ptr_n    = ptr;
    case (state)
      IDLE, RELEASE: begin
        gnt_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
        if (win_valid) begin
          state_n  = GRANT;
          gnt_n    = NUM_REQ'(1) << win;
          gnt_id_n = win;
          busy_n   = 1'b1;
          cnt_n    = win_len;
          ptr_n    = ptr_adv;
        end
      end
      GRANT: begin
        if (beat) begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            gnt_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = RELEASE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      GNT    <= '0;
      GNT_ID <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      GNT    <= gnt_n;
      GNT_ID <= gnt_id_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
    end
  end

endmodule

// File: doc/dpu_mem_arbiter.md
Name: dpu_mem_arbiter

Overview:
- Transaction-level round-robin arbiter that shares the single DPU memory port (P_ADDR_BASE_MEM region) between the engine masters (CONV, POOL, LINEAR, MOVER) inside dut.
- Grants one requester at a time and holds the grant for the requester's whole burst.
- Counts data beats on the shared channel and releases the grant after the last beat.
- Sits between the engine master ports and the shared AXI mux, clocked by SYS_CLK.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_WIDTH, 8, width of burst-length field (AXI LEN, beats-1)
ID_WIDTH, 2, width of GNT_ID; must equal clog2(NUM_REQ)

Ports:
SYS_CLK  in  1  system clock
SYS_RST  in  1  reset, synchronous, active-high
REQ  in  NUM_REQ  per-requester request; level, held until its DONE
REQ_LEN  in  NUM_REQ*LEN_WIDTH  per-requester burst length-1; slice i = [i*LEN_WIDTH +: LEN_WIDTH]
BEAT_VALID  in  1  shared data-channel VALID
BEAT_READY  in  1  shared data-channel READY
GNT  out  NUM_REQ  one-hot grant, registered
GNT_ID  out  ID_WIDTH  index of granted requester, registered
BUSY  out  1  a grant is active
DONE  out  1  one-cycle pulse: burst of GNT_ID finished

Behaviour:
- Interface (already decided): one clock, SYS_CLK; reset is synchronous and active-high, named SYS_RST.
- Reset: GNT=0, GNT_ID=0, BUSY=0, DONE=0, state=IDLE, rr pointer=0, beat counter=0. SYS_RST asserted mid-burst aborts the grant at that edge; there is no DONE.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any REQ bit is set, the round-robin picker starts at the pointer and selects the first set bit at or above it, wrapping.
  - At the next edge: GNT=onehot(winner), GNT_ID=winner, BUSY=1, counter<=REQ_LEN[winner], pointer<=(winner+1) mod NUM_REQ, state->GRANT.
  - Latency: REQ seen in IDLE at edge t gives GNT high after edge t+1.
- GRANT:
  - Each cycle with BEAT_VALID&BEAT_READY is one beat.
  - If counter!=0, the counter decrements.
  - If counter==0, that beat is the last: at that edge GNT=0, BUSY=0, DONE=1, state->RELEASE.
- RELEASE:
  - DONE=1 for exactly this cycle.
  - Arbitration is evaluated as in IDLE; if REQ is non-zero, go straight to GRANT, otherwise go to IDLE.
  - Minimum gap between grants: one cycle with GNT=0.
- Boundaries:
  - REQ_LEN=0 gives a single-beat burst.
  - REQ_LEN=2^LEN_WIDTH-1 gives 256 beats with no overflow.
  - Beats in IDLE or RELEASE are ignored.
  - REQ deassertion during GRANT is ignored (protocol violation); the grant is held until the beat count completes.
  - REQ_LEN changes after grant are ignored; the length is sampled only at grant.
  - A REQ bit set at or after the DONE edge is arbitrated in RELEASE.
  - Wrap: with pointer=NUM_REQ-1 and REQ=0b0001 (NUM_REQ=4), requester 0 wins.
- Fairness: every asserted requester is granted within NUM_REQ grants.

Optional Feature:
- Macro: DPU_ARB_PRIO0_EN.
- Defined: requester 0 (MOVER) wins any arbitration in which REQ[0]=1, regardless of the pointer. The pointer still updates to winner+1.
- Undefined: pure round-robin as above.
- A grant in progress is never pre-empted in either mode.

Decomposition:
- Package dpu_arb_pkg:
  - state encoding constants: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2
  - default NUM_REQ and LEN_WIDTH
  - clog2 function
- One sub-module, dpu_rr_pick:
  - purely combinational
  - inputs REQ and pointer; outputs winner index and a valid flag
  - contains the DPU_ARB_PRIO0_EN override.
- The FSM, beat counter and registers stay in dpu_mem_arbiter.

Test Plan:
- Single request: REQ=0b0100, REQ_LEN[2]=3, beats every cycle -> GNT=0b0100 one cycle after REQ, DONE after 4th beat, pointer=3.
- All requesting: REQ=0b1111, every REQ_LEN=0 -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Stalled beats: REQ_LEN=1, BEAT_READY low for 5 cycles between beats -> grant held throughout, DONE only after the 2nd handshake.
- Wrap and max length: pointer=3, REQ=0b0001, REQ_LEN=255 -> requester 0 granted, DONE after exactly 256 beats.
- Reset mid-burst: SYS_RST for one cycle at beat 2 of 4 -> GNT=0, BUSY=0, no DONE, next grant goes to requester 0.
- DPU_ARB_PRIO0_EN defined, pointer=2, REQ=0b0101 -> requester 0 granted; undefined -> requester 2 granted.
